tilegen_priority_mixer: RTL and testbench

- Parametrised N-layer tile pixel serialiser and priority mixer. It generalises the fixed two-chip CUS43 chain to NUM_LAYERS layers of configurable depth.
- Each layer latches one tile row (planar pixel data plus colour and priority attributes) and shifts it out one pixel per pixel-enable, honouring FLIP.
- A registered mixer picks the highest-priority opaque pixel per dot and falls back to the background colour.
- Output {colour, pixel} drives the tilemap palette PROM address and the sprite/tile video mixer.

---
 rtl/tilegen_priority_mixer.sv | 155 +++++++++++++++
 tb/tb_tilegen_priority_mixer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tilegen_priority_mixer.sv
// N-layer tile row serialiser with a registered priority mixer.
// Each layer shifts one pixel per PIX_EN; the mixer picks the highest-priority opaque head.
module tilegen_layer #(
    parameter int BPP     = 3,
    parameter int TILE_W  = 8,
    parameter int COLOR_W = 8,
    parameter int PRI_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_en,
    input  logic                    load,
    input  logic                    flip,
    input  logic [TILE_W*BPP-1:0]   planes,
    input  logic [COLOR_W-1:0]      cli,
    input  logic [PRI_W-1:0]        pri_in,
    output logic [BPP-1:0]          head,
    output logic [COLOR_W-1:0]      color,
    output logic [PRI_W-1:0]        pri,
    output logic                    active
);
    localparam int RW = $clog2(TILE_W + 1);

    logic [TILE_W*BPP-1:0] shreg;
    logic                  flip_q;
    logic [RW-1:0]         rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            color  <= '0;
            pri    <= '0;
            flip_q <= 1'b0;
            rem    <= '0;
        end else if (pix_en) begin
            if (load) begin
                shreg  <= planes;
                color  <= cli;
                pri    <= pri_in;
                flip_q <= flip;
                rem    <= RW'(TILE_W);
            end else if (rem != '0) begin
                // Flipped rows are read from the top slot, so shift toward it
                shreg <= flip_q ? (shreg << BPP) : (shreg >> BPP);
                rem   <= rem - RW'(1);
            end
        end
    end

    assign active = (rem != '0);
    assign head   = !active ? '1 :
                    flip_q  ? shreg[(TILE_W-1)*BPP +: BPP] : shreg[BPP-1:0];
endmodule

module tilegen_priority_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int BPP        = 3,
    parameter int TILE_W     = 8,
    parameter int COLOR_W    = 8,
    parameter int PRI_W      = 3,
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           CLK_6M,
    input  logic                           rst,
    input  logic                           PIX_EN,
    input  logic [NUM_LAYERS-1:0]          LOAD,
    input  logic [NUM_LAYERS*TILE_W*BPP-1:0] PLANES,
    input  logic [NUM_LAYERS*COLOR_W-1:0]  CLI,
    input  logic [NUM_LAYERS*PRI_W-1:0]    PRI,
    input  logic [NUM_LAYERS-1:0]          LAYER_EN,
    input  logic                           FLIP,
    input  logic                           BLANK,
    input  logic [COLOR_W-1:0]             BACKCOLOR,
    output logic [COLOR_W+BPP-1:0]         DOT,
    output logic [PRI_W-1:0]               PRO,
    output logic [LW-1:0]                  WIN,
    output logic                           OPAQUE,
    output logic                           DOT_VALID
);
    localparam logic [BPP-1:0] TRANSP = '1;

    logic [NUM_LAYERS-1:0][BPP-1:0]     head;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] color;
    logic [NUM_LAYERS-1:0][PRI_W-1:0]   pri;
    logic [NUM_LAYERS-1:0]              active;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        tilegen_layer #(
            .BPP(BPP), .TILE_W(TILE_W), .COLOR_W(COLOR_W), .PRI_W(PRI_W)
        ) u_layer (
            .clk    (CLK_6M),
            .rst    (rst),
            .pix_en (PIX_EN),
            .load   (LOAD[g]),
            .flip   (FLIP),
            .planes (PLANES[g*TILE_W*BPP +: TILE_W*BPP]),
            .cli    (CLI[g*COLOR_W +: COLOR_W]),
            .pri_in (PRI[g*PRI_W +: PRI_W]),
            .head   (head[g]),
            .color  (color[g]),
            .pri    (pri[g]),
            .active (active[g])
        );
    end

    logic               found;
    logic [PRI_W-1:0]   best_pri;
    logic [LW-1:0]      best_idx;
    logic [COLOR_W-1:0] best_col;
    logic [BPP-1:0]     best_pix;

    // Strict greater-than while scanning upward keeps the lowest index on ties
    always_comb begin
        found    = 1'b0;
        best_pri = '0;
        best_idx = '0;
        best_col = '0;
        best_pix = TRANSP;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (LAYER_EN[i] && active[i] && head[i] != TRANSP &&
                (!found || pri[i] > best_pri)) begin
                found    = 1'b1;
                best_pri = pri[i];
                best_idx = LW'(i);
                best_col = color[i];
                best_pix = head[i];
            end
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            DOT       <= '0;
            PRO       <= '0;
            WIN       <= '0;
            OPAQUE    <= 1'b0;
            DOT_VALID <= 1'b0;
        end else if (PIX_EN) begin
            DOT_VALID <= ~BLANK;
            if (found && !BLANK) begin
                DOT    <= {best_col, best_pix};
                PRO    <= best_pri;
                WIN    <= best_idx;
                OPAQUE <= 1'b1;
            end else begin
                DOT    <= {BACKCOLOR, TRANSP};
                PRO    <= '0;
                WIN    <= '0;
                OPAQUE <= 1'b0;
            end
        end else begin
            DOT_VALID <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tilegen_priority_mixer.sv
// Scoreboard bench: a pixel-index model of each layer predicts every output edge.
module tb_tilegen_priority_mixer;
    localparam int NL  = 4;
    localparam int BPP = 3;
    localparam int TW  = 8;
    localparam int CW  = 8;
    localparam int PW  = 3;
    localparam int LW  = 2;

    logic                  CLK_6M = 1'b0;
    logic                  rst, PIX_EN, FLIP, BLANK;
    logic [NL-1:0]         LOAD, LAYER_EN;
    logic [NL*TW*BPP-1:0]  PLANES;
    logic [NL*CW-1:0]      CLI;
    logic [NL*PW-1:0]      PRI;
    logic [CW-1:0]         BACKCOLOR;
    logic [CW+BPP-1:0]     DOT;
    logic [PW-1:0]         PRO;
    logic [LW-1:0]         WIN;
    logic                  OPAQUE, DOT_VALID;

    tilegen_priority_mixer #(
        .NUM_LAYERS(NL), .BPP(BPP), .TILE_W(TW), .COLOR_W(CW), .PRI_W(PW)
    ) dut (
        .CLK_6M(CLK_6M), .rst(rst), .PIX_EN(PIX_EN), .LOAD(LOAD), .PLANES(PLANES),
        .CLI(CLI), .PRI(PRI), .LAYER_EN(LAYER_EN), .FLIP(FLIP), .BLANK(BLANK),
        .BACKCOLOR(BACKCOLOR), .DOT(DOT), .PRO(PRO), .WIN(WIN), .OPAQUE(OPAQUE),
        .DOT_VALID(DOT_VALID)
    );

    always #5 CLK_6M = ~CLK_6M;

    typedef struct packed {
        logic [CW+BPP-1:0] dot;
        logic [PW-1:0]     pro;
        logic [LW-1:0]     win;
        logic              opq;
        logic              vld;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_chk = 0;
    int   n_err = 0;

    int             m_rem  [NL];
    logic [BPP-1:0] m_pix  [NL][TW];
    logic [CW-1:0]  m_col  [NL];
    logic [PW-1:0]  m_pri  [NL];
    bit             m_flip [NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [BPP-1:0] m_head(input int i);
        int idx;
        if (m_rem[i] == 0) return '1;
        idx = TW - m_rem[i];
        return m_flip[i] ? m_pix[i][TW-1-idx] : m_pix[i][idx];
    endfunction

    // One clock: predict, update model, clock, then compare
    task automatic cycle();
        exp_t e, o;
        bit found;
        int bi;
        logic [PW-1:0] bp;
        found = 0; bi = 0; bp = '0;
        if (rst) e = '0;
        else if (!PIX_EN) begin
            e = last_exp;
            e.vld = 1'b0;
        end else begin
            for (int i = 0; i < NL; i++)
                if (LAYER_EN[i] && m_rem[i] > 0 && m_head(i) != 3'b111)
                    if (!found || m_pri[i] > bp) begin
                        found = 1; bp = m_pri[i]; bi = i;
                    end
            if (found && !BLANK) begin
                e.dot = {m_col[bi], m_head(bi)};
                e.pro = m_pri[bi];
                e.win = LW'(bi);
                e.opq = 1'b1;
            end else begin
                e.dot = {BACKCOLOR, 3'b111};
                e.pro = '0;
                e.win = '0;
                e.opq = 1'b0;
            end
            e.vld = !BLANK;
        end
        exp_q.push_back(e);
        last_exp = e;
        for (int i = 0; i < NL; i++) begin
            if (rst) begin
                m_rem[i] = 0; m_col[i] = '0; m_pri[i] = '0; m_flip[i] = 0;
            end else if (PIX_EN) begin
                if (LOAD[i]) begin
                    for (int p = 0; p < TW; p++) m_pix[i][p] = PLANES[(i*TW+p)*BPP +: BPP];
                    m_col[i] = CLI[i*CW +: CW];
                    m_pri[i] = PRI[i*PW +: PW];
                    m_flip[i] = FLIP;
                    m_rem[i] = TW;
                end else if (m_rem[i] > 0) m_rem[i]--;
            end
        end
        @(posedge CLK_6M);
        #1;
        o = exp_q.pop_front();
        chk("dot", 32'(DOT), 32'(o.dot));
        chk("pro", 32'(PRO), 32'(o.pro));
        chk("win", 32'(WIN), 32'(o.win));
        chk("opaque", 32'(OPAQUE), 32'(o.opq));
        chk("dot_valid", 32'(DOT_VALID), 32'(o.vld));
    endtask

    task automatic set_row(input int l, input logic [TW*BPP-1:0] row,
                           input logic [CW-1:0] c, input logic [PW-1:0] p);
        PLANES[l*TW*BPP +: TW*BPP] = row;
        CLI[l*CW +: CW] = c;
        PRI[l*PW +: PW] = p;
    endtask

    function automatic logic [TW*BPP-1:0] ramp(input bit down);
        logic [TW*BPP-1:0] r;
        for (int p = 0; p < TW; p++) r[p*BPP +: BPP] = down ? BPP'(TW-1-p) : BPP'(p);
        return r;
    endfunction

    function automatic logic [TW*BPP-1:0] solid(input logic [BPP-1:0] v);
        logic [TW*BPP-1:0] r;
        for (int p = 0; p < TW; p++) r[p*BPP +: BPP] = v;
        return r;
    endfunction

    task automatic load_step(input logic [NL-1:0] m);
        LOAD = m;
        cycle();
        LOAD = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst = 1; PIX_EN = 0; LOAD = '0; PLANES = '0; CLI = '0; PRI = '0;
        LAYER_EN = '1; FLIP = 0; BLANK = 0; BACKCOLOR = 8'h5A;
        last_exp = '0;
        for (int i = 0; i < NL; i++) begin
            m_rem[i] = 0; m_col[i] = '0; m_pri[i] = '0; m_flip[i] = 0;
        end
        #2;
        cycle();
        cycle();
        rst = 0;
        PIX_EN = 1;
        cycle();
        chk("bg_dot_const", 32'(DOT), 32'h2D7);
        run(2);

        // Ramp row, no flip, then flipped
        set_row(0, ramp(0), 8'h12, 3'd3);
        load_step(4'b0001);
        run(10);
        FLIP = 1;
        load_step(4'b0001);
        FLIP = 0;
        run(10);

        // Priority, tie-break and layer enable
        set_row(0, solid(3'd1), 8'h21, 3'd2);
        set_row(2, solid(3'd3), 8'h43, 3'd5);
        load_step(4'b0101);
        run(2);
        chk("pri_win", 32'(WIN), 32'd2);
        set_row(2, solid(3'd3), 8'h43, 3'd2);
        load_step(4'b0101);
        run(2);
        chk("tie_win", 32'(WIN), 32'd0);
        LAYER_EN = 4'b1110;
        run(2);
        chk("en_win", 32'(WIN), 32'd2);
        LAYER_EN = '1;
        run(4);

        // Mid-row reload with PIX_EN gaps
        set_row(1, ramp(0), 8'h77, 3'd6);
        load_step(4'b0010);
        run(3);
        set_row(1, ramp(1), 8'h78, 3'd6);
        load_step(4'b0010);
        for (int k = 0; k < 12; k++) begin
            PIX_EN = k[0] ? 1'b0 : 1'b1;
            cycle();
        end
        PIX_EN = 1;
        run(3);

        // Reset mid-row, then blanking while shifting
        load_step(4'b0010);
        run(3);
        rst = 1; BLANK = 1;
        cycle();
        rst = 0;
        load_step(4'b0011);
        run(4);
        BLANK = 0;
        run(4);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            for (int l = 0; l < NL; l++)
                set_row(l, {$urandom, $urandom}, CW'($urandom), PW'($urandom));
            PIX_EN   = ($urandom_range(0, 3) != 0);
            LOAD     = NL'($urandom) & NL'($urandom);
            LAYER_EN = NL'($urandom) | NL'($urandom);
            FLIP     = 1'($urandom);
            BLANK    = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            BACKCOLOR = CW'($urandom);
            cycle();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
